l2_bus_controller: RTL and testbench

L2_BUS_CONTROLLER -- requirements
Module: l2_bus_controller

---
 rtl/l2_bus_controller_pkg.sv | 38 +++
 rtl/snoop_timer.sv | 37 +++
 rtl/l2_bus_controller.sv | 164 ++++++++++++++++
 tb/tb_l2_bus_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_bus_controller_pkg.sv
// Shared encodings for the L2 bus controller: request ops, snoop results and FSM states.
package l2_bus_controller_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RWITM = 2'd2,
        OP_INVAL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'd0,
        SNP_HIT   = 2'd1,
        SNP_HITM  = 2'd2
    } snoop_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_SNOOP   = 3'd3,
        ST_WAIT_WB = 3'd4,
        ST_DATA    = 3'd5,
        ST_WDATA   = 3'd6,
        ST_RESP    = 3'd7
    } state_e;

    // Ops that return a line to the L2.
    function automatic logic is_fill_op(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_RWITM);
    endfunction

    // Encoding 3 is reserved; it must never reach rsp_snoop.
    function automatic logic [1:0] clean_snoop(input logic [1:0] res);
        return (res == 2'd3) ? SNP_NOHIT : res;
    endfunction

endpackage

// File: rtl/snoop_timer.sv
// Snoop window timer: counts from 0 after start and flags expiry if no hit arrives in time.
module snoop_timer #(
    parameter int unsigned SNOOP_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hit,
    output logic expired
);

    localparam logic [3:0] LAST_COUNT = 4'(SNOOP_TIMEOUT - 1);

    logic [3:0] count_r;
    logic       running_r;

    // Counter runs from the first snoop cycle until a hit or expiry closes the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= 4'd0;
            running_r <= 1'b0;
        end else if (start) begin
            count_r   <= 4'd0;
            running_r <= 1'b1;
        end else if (running_r && (hit || expired)) begin
            count_r   <= 4'd0;
            running_r <= 1'b0;
        end else if (running_r) begin
            count_r   <= count_r + 4'd1;
        end else begin
            count_r   <= count_r;
        end
    end

    assign expired = running_r && !hit && (count_r == LAST_COUNT);

endmodule

// File: rtl/l2_bus_controller.sv
// Bridges single L2 line requests onto the shared snooping bus and returns one completion each.
module l2_bus_controller
    import l2_bus_controller_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 32,
    parameter int unsigned LINE_BITS     = 512,
    parameter int unsigned SNOOP_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_snoop,
    output logic [LINE_BITS-1:0] rsp_rdata,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic                 bus_op_valid,
    output logic [1:0]           bus_op,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic                 bus_wdata_valid,
    output logic [LINE_BITS-1:0] bus_wdata,
    input  logic                 bus_rdata_valid,
    input  logic [LINE_BITS-1:0] bus_rdata,
    input  logic                 snoop_valid,
    input  logic [1:0]           snoop_result
);

    state_e               state_r, state_s;
    logic [1:0]           op_r, snoop_r, snoop_now_s;
    logic [ADDR_BITS-1:0] addr_r;
    logic [LINE_BITS-1:0] wdata_r;
    logic                 accept_s, snoop_hit_s, snoop_expired_s, timer_start_s;

    logic                 req_ready_s, rsp_valid_s, bus_req_s, bus_op_valid_s, bus_wdata_valid_s;
    logic [1:0]           rsp_snoop_s, bus_op_s;
    logic [ADDR_BITS-1:0] bus_addr_s;
    logic [LINE_BITS-1:0] rsp_rdata_s, bus_wdata_s;

    assign accept_s      = req_valid && req_ready;
    assign snoop_hit_s   = (state_r == ST_SNOOP) && snoop_valid;
    assign timer_start_s = (state_r == ST_ADDR);
    assign snoop_now_s   = snoop_hit_s ? clean_snoop(snoop_result) : SNP_NOHIT;

    snoop_timer #(.SNOOP_TIMEOUT(SNOOP_TIMEOUT)) u_snoop_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start_s),
        .hit     (snoop_hit_s),
        .expired (snoop_expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    state_s = accept_s ? ST_ARB : ST_IDLE;
            ST_ARB:     state_s = bus_gnt ? ST_ADDR : ST_ARB;
            ST_ADDR:    state_s = ST_SNOOP;
            ST_SNOOP: begin
                if (!(snoop_hit_s || snoop_expired_s)) begin
                    state_s = ST_SNOOP;
                end else if (op_r == OP_WRITE) begin
                    state_s = ST_WDATA;
                end else if (op_r == OP_INVAL) begin
                    state_s = ST_RESP;
                end else if (snoop_now_s == SNP_HITM) begin
                    state_s = ST_WAIT_WB;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WAIT_WB: state_s = bus_rdata_valid ? ST_RESP : ST_WAIT_WB;
            ST_DATA:    state_s = bus_rdata_valid ? ST_RESP : ST_DATA;
            ST_WDATA:   state_s = ST_RESP;
            ST_RESP:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Request fields latch at the handshake; the snoop result latches when the window closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= 2'd0;
            addr_r  <= {ADDR_BITS{1'b0}};
            wdata_r <= {LINE_BITS{1'b0}};
            snoop_r <= 2'd0;
        end else if (accept_s) begin
            op_r    <= req_op;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            snoop_r <= SNP_NOHIT;
        end else if (snoop_hit_s || snoop_expired_s) begin
            snoop_r <= snoop_now_s;
        end else begin
            snoop_r <= snoop_r;
        end
    end

    // Output decode from the next state so every port comes straight from a flop.
    always_comb begin
        req_ready_s       = (state_s == ST_IDLE);
        bus_req_s         = (state_s != ST_IDLE);
        bus_op_valid_s    = (state_s == ST_ADDR);
        bus_op_s          = bus_op_valid_s ? op_r : 2'd0;
        bus_addr_s        = bus_op_valid_s ? addr_r : {ADDR_BITS{1'b0}};
        bus_wdata_valid_s = (state_s == ST_WDATA);
        bus_wdata_s       = bus_wdata_valid_s ? wdata_r : {LINE_BITS{1'b0}};
        rsp_valid_s       = (state_s == ST_RESP);
        rsp_snoop_s       = SNP_NOHIT;
        rsp_rdata_s       = rsp_rdata;
        if (rsp_valid_s) begin
            rsp_snoop_s = (state_r == ST_SNOOP) ? snoop_now_s : snoop_r;
        end else begin
            rsp_snoop_s = SNP_NOHIT;
        end
        // Fill data is taken on the same edge that enters RESP and then held.
        if (rsp_valid_s && (state_r != ST_RESP)) begin
            rsp_rdata_s = is_fill_op(op_r) ? bus_rdata : {LINE_BITS{1'b0}};
        end else begin
            rsp_rdata_s = rsp_rdata;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_snoop       <= 2'd0;
            rsp_rdata       <= {LINE_BITS{1'b0}};
            bus_req         <= 1'b0;
            bus_op_valid    <= 1'b0;
            bus_op          <= 2'd0;
            bus_addr        <= {ADDR_BITS{1'b0}};
            bus_wdata_valid <= 1'b0;
            bus_wdata       <= {LINE_BITS{1'b0}};
        end else begin
            req_ready       <= req_ready_s;
            rsp_valid       <= rsp_valid_s;
            rsp_snoop       <= rsp_snoop_s;
            rsp_rdata       <= rsp_rdata_s;
            bus_req         <= bus_req_s;
            bus_op_valid    <= bus_op_valid_s;
            bus_op          <= bus_op_s;
            bus_addr        <= bus_addr_s;
            bus_wdata_valid <= bus_wdata_valid_s;
            bus_wdata       <= bus_wdata_s;
        end
    end

endmodule

// File: tb/tb_l2_bus_controller.sv
// Directed, table-driven bench for l2_bus_controller with hand-written reset and back-to-back cases.
module tb_l2_bus_controller;
    import l2_bus_controller_pkg::*;

    localparam int AB = 32;
    localparam int LB = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [AB-1:0] req_addr;
    logic [LB-1:0] req_wdata;
    logic          rsp_valid;
    logic [1:0]    rsp_snoop;
    logic [LB-1:0] rsp_rdata;
    logic          bus_req, bus_gnt, bus_op_valid;
    logic [1:0]    bus_op;
    logic [AB-1:0] bus_addr;
    logic          bus_wdata_valid;
    logic [LB-1:0] bus_wdata;
    logic          bus_rdata_valid;
    logic [LB-1:0] bus_rdata;
    logic          snoop_valid;
    logic [1:0]    snoop_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_bus_controller #(.ADDR_BITS(AB), .LINE_BITS(LB), .SNOOP_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop), .rsp_rdata(rsp_rdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_op_valid(bus_op_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_wdata_valid(bus_wdata_valid), .bus_wdata(bus_wdata),
        .bus_rdata_valid(bus_rdata_valid), .bus_rdata(bus_rdata),
        .snoop_valid(snoop_valid), .snoop_result(snoop_result)
    );

    typedef struct {
        logic [1:0]    op;
        logic [AB-1:0] addr;
        logic [LB-1:0] wdata;
        int            gnt_dly;     // ARB cycles before bus_gnt
        int            snp_dly;     // SNOOP cycles before snoop_valid, -1 = never
        logic [1:0]    snp;
        int            rd_dly;      // cycles after the snoop window before bus_rdata_valid
        logic [LB-1:0] rdata;
        int            stray_rd_t;  // cycle of an extra bus_rdata_valid pulse, -1 = none
        int            stray_snp_t; // cycle of an extra snoop_valid pulse, -1 = none
        bit            hold;        // keep req_valid high for back-to-back
        logic [1:0]    exp_snp;
        logic [LB-1:0] exp_rdata;
        bit            exp_wb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Called on a negedge; that negedge is cycle 0 of the transaction.
    task automatic run_txn(input vec_t v, input int idx);
        int t_a, t_s, t_res, t_r, t_rsp, k;
        int n_addr, n_wd, n_rsp, addr_t, wd_t, rsp_t;
        logic [1:0]    seen_op, seen_snp;
        logic [AB-1:0] seen_addr;
        logic [LB-1:0] seen_wd, seen_rd;
        bit fill, saw_wb;
        fill   = (v.op == OP_READ) || (v.op == OP_RWITM);
        t_a    = 2 + v.gnt_dly;
        t_s    = (v.snp_dly >= 0) ? t_a + 1 + v.snp_dly : -1;
        t_res  = (v.snp_dly >= 0) ? t_s : t_a + 15;
        t_r    = fill ? t_res + 1 + v.rd_dly : -1;
        t_rsp  = fill ? t_r + 1 : ((v.op == OP_WRITE) ? t_res + 2 : t_res + 1);
        n_addr = 0; n_wd = 0; n_rsp = 0; addr_t = -1; wd_t = -1; rsp_t = -1;
        seen_op = 2'd0; seen_snp = 2'd0; seen_addr = '0; seen_wd = '0; seen_rd = '0;
        saw_wb = 1'b0;

        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        k = 0;
        while (!req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            chk_i($sformatf("v%0d.accept", idx), 0, 1);
            req_valid = 1'b0;
            return;
        end

        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            if (!v.hold) req_valid = 1'b0;
            bus_gnt         = (t >= 1 + v.gnt_dly);
            snoop_valid     = (t == t_s) || (t == v.stray_snp_t);
            snoop_result    = (t == t_s) ? v.snp : 2'd2;
            bus_rdata_valid = (t == t_r) || (t == v.stray_rd_t);
            bus_rdata       = (t == t_r) ? v.rdata : {64{8'hEE}};
            if (dut.state_r == ST_WAIT_WB) saw_wb = 1'b1;
            if (bus_op_valid) begin
                n_addr++; addr_t = t; seen_op = bus_op; seen_addr = bus_addr;
            end
            if (bus_wdata_valid) begin
                n_wd++; wd_t = t; seen_wd = bus_wdata;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (rsp_t < 0) begin
                    rsp_t = t; seen_snp = rsp_snoop; seen_rd = rsp_rdata;
                    chk_i($sformatf("v%0d.ready_in_resp", idx), int'(req_ready), 0);
                end
            end
            if (rsp_t >= 0 && t == rsp_t + 1) begin
                chk_i($sformatf("v%0d.ready_after", idx), int'(req_ready), 1);
                chk_i($sformatf("v%0d.busreq_after", idx), int'(bus_req), 0);
                chk_i($sformatf("v%0d.rsp_single", idx), int'(rsp_valid), 0);
                chk_w($sformatf("v%0d.rdata_hold", idx), rsp_rdata, v.exp_rdata);
                break;
            end
        end
        bus_gnt = 1'b0; snoop_valid = 1'b0; bus_rdata_valid = 1'b0;

        chk_i($sformatf("v%0d.addr_count", idx), n_addr, 1);
        chk_i($sformatf("v%0d.addr_cycle", idx), addr_t, t_a);
        chk_i($sformatf("v%0d.bus_op", idx), int'(seen_op), int'(v.op));
        chk_i($sformatf("v%0d.bus_addr", idx), int'(seen_addr), int'(v.addr));
        chk_i($sformatf("v%0d.wdata_count", idx), n_wd, (v.op == OP_WRITE) ? 1 : 0);
        if (v.op == OP_WRITE) begin
            chk_i($sformatf("v%0d.wdata_cycle", idx), wd_t, t_res + 1);
            chk_w($sformatf("v%0d.wdata", idx), seen_wd, v.wdata);
        end
        chk_i($sformatf("v%0d.rsp_count", idx), n_rsp, 1);
        chk_i($sformatf("v%0d.rsp_cycle", idx), rsp_t, t_rsp);
        chk_i($sformatf("v%0d.rsp_snoop", idx), int'(seen_snp), int'(v.exp_snp));
        chk_w($sformatf("v%0d.rsp_rdata", idx), seen_rd, v.exp_rdata);
        chk_i($sformatf("v%0d.wait_wb", idx), int'(saw_wb), int'(v.exp_wb));
    endtask

    int n_rst_rsp;

    initial begin
        //          op        addr           wdata              gnt snp  res    rd  rdata              srd  ssnp hold exp_snp exp_rdata          wb
        vecs[0] = '{OP_READ,  32'h0000_1040, {LB{1'b0}},         2,  0, 2'd0,  3, {64{8'hA5}},       -1, -1, 1'b0, 2'd0, {64{8'hA5}},       1'b0};
        vecs[1] = '{OP_RWITM, 32'h0000_2000, {LB{1'b0}},         0,  1, 2'd2,  1, {32{16'h1234}},    -1, -1, 1'b0, 2'd2, {32{16'h1234}},    1'b1};
        vecs[2] = '{OP_WRITE, 32'h0000_3000, {LB{1'b1}},         1,  0, 2'd1,  0, {LB{1'b0}},        -1, -1, 1'b0, 2'd1, {LB{1'b0}},        1'b0};
        vecs[3] = '{OP_INVAL, 32'h0000_4080, {LB{1'b0}},         0, -1, 2'd0,  0, {LB{1'b0}},        -1, -1, 1'b0, 2'd0, {LB{1'b0}},        1'b0};
        vecs[4] = '{OP_READ,  32'h0000_50C0, {LB{1'b0}},         0,  2, 2'd1,  0, {64{8'h5A}},        3,  1, 1'b1, 2'd1, {64{8'h5A}},       1'b0};
        vecs[5] = '{OP_INVAL, 32'h0000_6000, {LB{1'b0}},         0,  0, 2'd2,  0, {LB{1'b0}},        -1, -1, 1'b0, 2'd2, {LB{1'b0}},        1'b0};
        vecs[6] = '{OP_READ,  32'h0000_7040, {LB{1'b0}},         1, -1, 2'd0,  2, {64{8'h0F}},       -1, -1, 1'b0, 2'd0, {64{8'h0F}},       1'b0};
        vecs[7] = '{OP_WRITE, 32'h0000_8000, {16{32'hDEAD_BEEF}}, 0, 3, 2'd2,  0, {LB{1'b0}},        -1, -1, 1'b0, 2'd2, {LB{1'b0}},        1'b0};
        vecs[8] = '{OP_READ,  32'h0000_9100, {LB{1'b0}},         3,  4, 2'd1,  0, {64{8'h3C}},       -1, -1, 1'b0, 2'd1, {64{8'h3C}},       1'b0};

        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0;
        bus_gnt = 1'b0; bus_rdata_valid = 1'b0; bus_rdata = '0;
        snoop_valid = 1'b0; snoop_result = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk_i("reset.req_ready", int'(req_ready), 1);
        chk_i("reset.bus_req", int'(bus_req), 0);
        chk_i("reset.rsp_valid", int'(rsp_valid), 0);
        chk_i("reset.bus_op_valid", int'(bus_op_valid), 0);
        chk_i("reset.bus_wdata_valid", int'(bus_wdata_valid), 0);
        chk_w("reset.rsp_rdata", rsp_rdata, {LB{1'b0}});
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // Abandon a READ while it waits in DATA; nothing may complete afterwards.
        req_valid = 1'b1; req_op = OP_READ; req_addr = 32'h0000_A000; req_wdata = '0;
        @(negedge clk); req_valid = 1'b0; bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0;
        @(negedge clk); snoop_valid = 1'b1; snoop_result = 2'd0;
        @(negedge clk); snoop_valid = 1'b0;
        chk_i("rst_mid.busy", int'(bus_req), 1);
        reset = 1'b1;
        #1;
        chk_i("rst_mid.req_ready", int'(req_ready), 1);
        chk_i("rst_mid.bus_req", int'(bus_req), 0);
        chk_i("rst_mid.rsp_valid", int'(rsp_valid), 0);
        chk_w("rst_mid.rsp_rdata", rsp_rdata, {LB{1'b0}});
        @(negedge clk); bus_rdata_valid = 1'b1; bus_rdata = {64{8'h77}};
        @(negedge clk); bus_rdata_valid = 1'b0; reset = 1'b0;
        n_rst_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) n_rst_rsp++;
        end
        chk_i("rst_mid.no_rsp", n_rst_rsp, 0);
        chk_i("rst_mid.ready_after", int'(req_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
